// File: rtl/huff_min2_select_pkg.sv
// Shared definitions for the Huffman minimum-pair selector: default field
// widths, the scanner state encoding and the packed candidate record.
package huff_min2_select_pkg;

    localparam int HUFF_NODES    = 16;
    localparam int HUFF_W_WEIGHT = 8;
    localparam int HUFF_W_IDX    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One minimum candidate at the default widths: node index and its weight.
    typedef struct packed {
        logic [HUFF_W_IDX-1:0]    idx;
        logic [HUFF_W_WEIGHT-1:0] weight;
    } cand_t;

    // Active-node count saturating at 2 (the merge stage only needs 0, 1, 2+).
    function automatic logic [1:0] found_inc(input logic [1:0] f);
        return (f >= 2'd2) ? 2'd2 : f + 2'd1;
    endfunction

endpackage

// File: rtl/huff_min2_select_if.sv
// Control, result and table-read signals of the minimum-pair selector.
// master: the tree builder that starts scans and serves the node table.
// slave:  the selector itself.
interface huff_min2_select_if
    import huff_min2_select_pkg::*;
#(
    parameter int W_WEIGHT = HUFF_W_WEIGHT,
    parameter int W_IDX    = HUFF_W_IDX
) ();

    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic [W_IDX-1:0]    min1_idx;
    logic [W_WEIGHT-1:0] min1_w;
    logic [W_IDX-1:0]    min2_idx;
    logic [W_WEIGHT-1:0] min2_w;
    logic [1:0]          found;
    logic                rd_en;
    logic [W_IDX-1:0]    rd_addr;
    logic [W_WEIGHT-1:0] rd_weight;
    logic                rd_active;

    modport master (
        output start, abort, rd_weight, rd_active,
        input  busy, done, min1_idx, min1_w, min2_idx, min2_w, found,
               rd_en, rd_addr
    );

    modport slave (
        input  start, abort, rd_weight, rd_active,
        output busy, done, min1_idx, min1_w, min2_idx, min2_w, found,
               rd_en, rd_addr
    );

endinterface

// File: rtl/huff_min2_update.sv
// Combinational step of the two-minimum search: folds one returned table
// entry into the running (min1, min2, found) state. Candidates are packed
// as {idx, weight}. Strict < keeps the earlier-seen entry on weight ties.
module huff_min2_update
    import huff_min2_select_pkg::*;
#(
    parameter int W_WEIGHT = HUFF_W_WEIGHT,
    parameter int W_IDX    = HUFF_W_IDX
) (
    input  logic                        valid,
    input  logic [W_IDX-1:0]            new_idx,
    input  logic [W_WEIGHT-1:0]         new_w,
    input  logic [W_IDX+W_WEIGHT-1:0]   min1_in,
    input  logic [W_IDX+W_WEIGHT-1:0]   min2_in,
    input  logic [1:0]                  found_in,
    output logic [W_IDX+W_WEIGHT-1:0]   min1_out,
    output logic [W_IDX+W_WEIGHT-1:0]   min2_out,
    output logic [1:0]                  found_out
);

    typedef struct packed {
        logic [W_IDX-1:0]    idx;
        logic [W_WEIGHT-1:0] weight;
    } cand_p_t;

    cand_p_t cur1;
    cand_p_t cur2;
    cand_p_t incoming;

    assign cur1     = min1_in;
    assign cur2     = min2_in;
    assign incoming = '{idx: new_idx, weight: new_w};

    // Insert the entry as new min1 (old min1 slides down) or as new min2.
    always_comb begin
        min1_out  = min1_in;
        min2_out  = min2_in;
        found_out = found_in;
        if (valid) begin
            if (found_in == 2'd0 || new_w < cur1.weight) begin
                min2_out = cur1;
                min1_out = incoming;
            end else if (found_in < 2'd2 || new_w < cur2.weight) begin
                min2_out = incoming;
            end
            found_out = found_inc(found_in);
        end
    end

endmodule

// File: rtl/huff_min2_select.sv
// Sequential scanner that walks the node table once over a 1-cycle-latency
// read port and reports the two lightest active nodes plus a saturating
// count of active nodes. Results are published one cycle after the final
// compare, together with a single-cycle done pulse, and then held.
module huff_min2_select
    import huff_min2_select_pkg::*;
#(
    parameter int NODES    = HUFF_NODES,
    parameter int W_WEIGHT = HUFF_W_WEIGHT,
    parameter int W_IDX    = HUFF_W_IDX
) (
    input  logic                clk,
    input  logic                rst,
    huff_min2_select_if.slave   bus
);

    if (NODES < 2 || (1 << W_IDX) < NODES) begin : g_bad_params
        $error("huff_min2_select: need NODES >= 2 and 2**W_IDX >= NODES");
    end

    typedef struct packed {
        logic [W_IDX-1:0]    idx;
        logic [W_WEIGHT-1:0] weight;
    } cand_p_t;

    localparam logic [W_IDX-1:0] LAST_ADDR = W_IDX'(NODES - 1);

    state_t           state_reg, state_next;
    logic [W_IDX-1:0] addr_reg, addr_next;
    logic             scan_clear;
    logic             commit;

    // Read pipeline: marks the cycle in which returned data belongs to a read.
    logic             pend_reg;
    logic [W_IDX-1:0] pend_idx_reg;

    // Working minima, private to the running scan.
    cand_p_t          min1_reg, min2_reg, min1_next, min2_next;
    logic [1:0]       found_reg, found_next;

    // Published results, only touched when a scan completes.
    cand_p_t          res_min1_reg, res_min2_reg;
    logic [1:0]       res_found_reg;
    logic             done_reg;

    // State and read address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
        end
    end

    // Next-state logic; abort has priority over start and over completion.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        scan_clear = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_next = ST_SCAN;
                    addr_next  = '0;
                    scan_clear = 1'b1;
                end
            end
            ST_SCAN: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                    addr_next  = '0;
                end else if (addr_reg == LAST_ADDR) begin
                    state_next = ST_DRAIN;
                    addr_next  = '0;
                end else begin
                    addr_next  = addr_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_next = bus.abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                commit     = !bus.abort;
            end
            default: begin
                state_next = ST_IDLE;
                addr_next  = '0;
            end
        endcase
    end

    // Remember which index the data arriving next cycle belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg     <= 1'b0;
            pend_idx_reg <= '0;
        end else begin
            pend_reg     <= (state_reg == ST_SCAN) && !bus.abort;
            pend_idx_reg <= addr_reg;
        end
    end

    huff_min2_update #(
        .W_WEIGHT (W_WEIGHT),
        .W_IDX    (W_IDX)
    ) u_update (
        .valid     (pend_reg & bus.rd_active),
        .new_idx   (pend_idx_reg),
        .new_w     (bus.rd_weight),
        .min1_in   (min1_reg),
        .min2_in   (min2_reg),
        .found_in  (found_reg),
        .min1_out  (min1_next),
        .min2_out  (min2_next),
        .found_out (found_next)
    );

    // Working minima: cleared on scan start, folded once per returned entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min1_reg  <= '0;
            min2_reg  <= '0;
            found_reg <= '0;
        end else if (scan_clear) begin
            min1_reg  <= '0;
            min2_reg  <= '0;
            found_reg <= '0;
        end else begin
            min1_reg  <= min1_next;
            min2_reg  <= min2_next;
            found_reg <= found_next;
        end
    end

    // Publish results with the done pulse; hold them otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_min1_reg  <= '0;
            res_min2_reg  <= '0;
            res_found_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= commit;
            if (commit) begin
                res_min1_reg  <= min1_reg;
                res_min2_reg  <= min2_reg;
                res_found_reg <= found_reg;
            end
        end
    end

    assign bus.rd_en    = (state_reg == ST_SCAN);
    assign bus.rd_addr  = addr_reg;
    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.done     = done_reg;
    assign bus.min1_idx = res_min1_reg.idx;
    assign bus.min1_w   = res_min1_reg.weight;
    assign bus.min2_idx = res_min2_reg.idx;
    assign bus.min2_w   = res_min2_reg.weight;
    assign bus.found    = res_found_reg;

endmodule

// File: tb/tb_huff_min2_select.sv
// Directed bench for huff_min2_select. Stimulus pushes hand-computed results
// (with the edge at which done must appear) into a queue; a negedge monitor
// checks done timing, result fields and the read address sequence.
module tb_huff_min2_select;
    import huff_min2_select_pkg::*;

    localparam int NODES = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    huff_min2_select_if #(.W_WEIGHT(8), .W_IDX(4)) bus ();

    huff_min2_select #(
        .NODES    (NODES),
        .W_WEIGHT (8),
        .W_IDX    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         done_edge;
        cand_t      m1;
        cand_t      m2;
        logic [1:0] found;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         edge_cnt = 0;
    int         s_edge = 0;
    int         exp_addr = 0;
    int         rd_cnt = 0;
    logic [7:0] tbl_w   [NODES];
    logic       tbl_act [NODES];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Node table with 1-cycle read latency; between reads it presents an
    // active zero-weight entry that the selector must ignore.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_weight <= tbl_w[bus.rd_addr];
            bus.rd_active <= tbl_act[bus.rd_addr];
        end else begin
            bus.rd_weight <= 8'd0;
            bus.rd_active <= 1'b1;
        end
    end

    // Monitor: done must appear exactly at the expected edge, once.
    always @(negedge clk) begin
        logic due;
        due = (sb_q.size() > 0) && (edge_cnt == sb_q[0].done_edge);
        if (bus.done || due) chk("done_pulse", 32'(bus.done), 32'(due));
        if (due) begin
            chk("min1_idx", 32'(bus.min1_idx), 32'(sb_q[0].m1.idx));
            chk("min1_w",   32'(bus.min1_w),   32'(sb_q[0].m1.weight));
            chk("min2_idx", 32'(bus.min2_idx), 32'(sb_q[0].m2.idx));
            chk("min2_w",   32'(bus.min2_w),   32'(sb_q[0].m2.weight));
            chk("found",    32'(bus.found),    32'(sb_q[0].found));
            $display("scan done @edge %0d: min1=(%0d,%0d) min2=(%0d,%0d) found=%0d",
                     edge_cnt, bus.min1_idx, bus.min1_w, bus.min2_idx, bus.min2_w, bus.found);
            void'(sb_q.pop_front());
        end
        if (bus.rd_en) begin
            chk("rd_addr", 32'(bus.rd_addr), 32'(exp_addr));
            exp_addr++;
            rd_cnt++;
        end
    end

    task automatic fill(input logic [7:0] w, input logic a);
        for (int i = 0; i < NODES; i++) begin
            tbl_w[i]   = w;
            tbl_act[i] = a;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        exp_addr  = 0;
        rd_cnt    = 0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        s_edge    = edge_cnt;
    endtask

    task automatic push_exp(input logic [3:0] i1, input logic [7:0] w1,
                            input logic [3:0] i2, input logic [7:0] w2,
                            input logic [1:0] f);
        exp_t e;
        e.done_edge = s_edge + NODES + 2;
        e.m1        = '{idx: i1, weight: w1};
        e.m2        = '{idx: i2, weight: w2};
        e.found     = f;
        sb_q.push_back(e);
    endtask

    task automatic finish_scan(input string name);
        repeat (22) @(posedge clk);
        #1;
        chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
        chk({name, "_rd_cycles"}, 32'(rd_cnt), 32'(NODES));
    endtask

    task automatic load_t1();
        fill(8'd0, 1'b0);
        tbl_w[0] = 8'd9; tbl_act[0] = 1'b1;
        tbl_w[1] = 8'd3; tbl_act[1] = 1'b1;
        tbl_w[2] = 8'd7; tbl_act[2] = 1'b1;
        tbl_w[3] = 8'd3; tbl_act[3] = 1'b1;
    endtask

    task automatic load_t2();
        fill(8'd1, 1'b0);
        tbl_w[5] = 8'd4; tbl_act[5] = 1'b1;
    endtask

    task automatic load_t4();
        for (int i = 0; i < NODES; i++) begin
            tbl_w[i]   = 8'(15 - i);
            tbl_act[i] = 1'b1;
        end
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_busy"},     32'(bus.busy),     32'd0);
        chk({name, "_done"},     32'(bus.done),     32'd0);
        chk({name, "_rd_en"},    32'(bus.rd_en),    32'd0);
        chk({name, "_rd_addr"},  32'(bus.rd_addr),  32'd0);
        chk({name, "_found"},    32'(bus.found),    32'd0);
        chk({name, "_min1_idx"}, 32'(bus.min1_idx), 32'd0);
        chk({name, "_min1_w"},   32'(bus.min1_w),   32'd0);
        chk({name, "_min2_idx"}, 32'(bus.min2_idx), 32'd0);
        chk({name, "_min2_w"},   32'(bus.min2_w),   32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        fill(8'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Tie on weight 3: lower index wins min1.
        load_t1();
        do_start();
        push_exp(4'd1, 8'd3, 4'd3, 8'd3, 2'd2);
        finish_scan("t1");

        // Single active entry.
        load_t2();
        do_start();
        push_exp(4'd5, 8'd4, 4'd0, 8'd0, 2'd1);
        finish_scan("t2");

        // No active entries: done still pulses with zeroed results.
        fill(8'd2, 1'b0);
        do_start();
        push_exp(4'd0, 8'd0, 4'd0, 8'd0, 2'd0);
        finish_scan("t3");

        // All active, descending weights.
        load_t4();
        do_start();
        push_exp(4'd15, 8'd0, 4'd14, 8'd1, 2'd2);
        finish_scan("t4");

        // All-ones weight compares normally.
        fill(8'd0, 1'b0);
        tbl_w[2] = 8'hFF; tbl_act[2] = 1'b1;
        tbl_w[7] = 8'hFF; tbl_act[7] = 1'b1;
        tbl_w[9] = 8'hFE; tbl_act[9] = 1'b1;
        do_start();
        push_exp(4'd9, 8'hFE, 4'd2, 8'hFF, 2'd2);
        finish_scan("t5");

        // Abort during scan cycle 6: no done, previous results kept.
        load_t1();
        do_start();
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rd_en", 32'(bus.rd_en), 32'd0);
        chk("abort_rd_cycles", 32'(rd_cnt), 32'd7);
        repeat (25) @(posedge clk);
        #1;
        chk("abort_hold_min1_idx", 32'(bus.min1_idx), 32'd9);
        chk("abort_hold_min2_w",   32'(bus.min2_w),   32'hFF);
        chk("abort_hold_found",    32'(bus.found),    32'd2);

        // Restart after abort completes normally.
        do_start();
        push_exp(4'd1, 8'd3, 4'd3, 8'd3, 2'd2);
        finish_scan("t6");

        // Second start mid-scan is ignored; done keeps its original timing.
        load_t4();
        do_start();
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("scan_hold_min1_idx", 32'(bus.min1_idx), 32'd1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        push_exp(4'd15, 8'd0, 4'd14, 8'd1, 2'd2);
        finish_scan("t7");

        // Asynchronous reset mid-scan zeroes outputs before the next edge.
        load_t2();
        do_start();
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Recovery scan after reset.
        do_start();
        push_exp(4'd5, 8'd4, 4'd0, 8'd0, 2'd1);
        finish_scan("t8");

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
